// File: rtl/power_sequencer_if.sv
// Signal bundle between the power sequencer and its controller/monitor side.
// The sequencer uses the slave view; the driving environment uses the master view.
interface power_sequencer_if;
    logic       power_req;
    logic       fault_clr;
    logic       error;
    logic [2:0] sel;
    logic       start;
    logic       fault_valid;
    logic [2:0] fault_code;
    logic [1:0] retry_cnt;
    logic       lockout;

    modport slave (
        input  power_req, fault_clr, error, sel,
        output start, fault_valid, fault_code, retry_cnt, lockout
    );

    modport master (
        output power_req, fault_clr, error, sel,
        input  start, fault_valid, fault_code, retry_cnt, lockout
    );
endinterface

// File: rtl/power_sequencer.sv
// Power-on sequencer: debounces the power request, soft-starts the supply, and
// retries a limited number of times after monitor faults before locking out.
module power_sequencer #(
    parameter int DEBOUNCE_CYCLES  = 50000,
    parameter int SOFTSTART_CYCLES = 500000,
    parameter int COOLDOWN_CYCLES  = 5000000,
    parameter int MAX_RETRIES      = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    power_sequencer_if.slave  bus
);

    localparam int CNT_W = 23;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t       DEBOUNCE_LOAD  = cnt_t'(DEBOUNCE_CYCLES - 1);
    localparam cnt_t       SOFTSTART_LOAD = cnt_t'(SOFTSTART_CYCLES - 1);
    localparam cnt_t       COOLDOWN_LOAD  = cnt_t'(COOLDOWN_CYCLES - 1);
    localparam logic [1:0] RETRY_MAX      = 2'(MAX_RETRIES);

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        SOFTSTART,
        ON,
        COOLDOWN,
        LOCKOUT
    } state_t;

    state_t     state, next_state;
    cnt_t       count, next_count;
    logic       req_meta, req_sync;
    logic [1:0] retry, next_retry;
    logic       fault_valid, next_fault_valid;
    logic [2:0] fault_code, next_fault_code;
    logic       start, next_start;
    logic       lockout, next_lockout;

    // start and lockout are registered from the next state so they line up
    // exactly with the state they describe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_meta    <= 1'b0;
            req_sync    <= 1'b0;
            state       <= IDLE;
            count       <= '0;
            retry       <= '0;
            fault_valid <= 1'b0;
            fault_code  <= '0;
            start       <= 1'b0;
            lockout     <= 1'b0;
        end else begin
            req_meta    <= bus.power_req;
            req_sync    <= req_meta;
            state       <= next_state;
            count       <= next_count;
            retry       <= next_retry;
            fault_valid <= next_fault_valid;
            fault_code  <= next_fault_code;
            start       <= next_start;
            lockout     <= next_lockout;
        end
    end

    always_comb begin
        next_state = state;
        next_count = count;
        case (state)
            IDLE: begin
                if (req_sync) begin
                    next_state = DEBOUNCE;
                    next_count = DEBOUNCE_LOAD;
                end
            end
            DEBOUNCE: begin
                if (!req_sync) begin
                    next_state = IDLE;
                end else if (count == '0) begin
                    next_state = SOFTSTART;
                    next_count = SOFTSTART_LOAD;
                end else begin
                    next_count = count - cnt_t'(1);
                end
            end
            SOFTSTART: begin
                if (!req_sync) begin
                    next_state = IDLE;
                end else if (count == '0) begin
                    next_state = ON;
                end else begin
                    next_count = count - cnt_t'(1);
                end
            end
            ON: begin
                // A fault outranks a simultaneous request drop.
                if (bus.error) begin
                    if (retry < RETRY_MAX) begin
                        next_state = COOLDOWN;
                        next_count = COOLDOWN_LOAD;
                    end else begin
                        next_state = LOCKOUT;
                    end
                end else if (!req_sync) begin
                    next_state = IDLE;
                end
            end
            COOLDOWN: begin
                if (count == '0) begin
                    if (req_sync) begin
                        next_state = SOFTSTART;
                        next_count = SOFTSTART_LOAD;
                    end else begin
                        next_state = IDLE;
                    end
                end else begin
                    next_count = count - cnt_t'(1);
                end
            end
            LOCKOUT: begin
                if (bus.fault_clr) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        next_retry       = retry;
        next_fault_valid = fault_valid;
        next_fault_code  = fault_code;
        if (bus.fault_clr) begin
            next_fault_valid = 1'b0;
            next_fault_code  = '0;
        end
        case (state)
            ON: begin
                if (bus.error) begin
                    next_fault_valid = 1'b1;
                    next_fault_code  = bus.sel;
                end else if (!req_sync) begin
                    next_retry = '0;
                end
            end
            COOLDOWN: begin
                if (count == '0 && retry != RETRY_MAX) begin
                    next_retry = retry + 2'd1;
                end
            end
            LOCKOUT: begin
                if (bus.fault_clr) begin
                    next_retry = '0;
                end
            end
            default: begin
            end
        endcase
        next_start   = (next_state == ON);
        next_lockout = (next_state == LOCKOUT);
    end

    assign bus.start       = start;
    assign bus.fault_valid = fault_valid;
    assign bus.fault_code  = fault_code;
    assign bus.retry_cnt   = retry;
    assign bus.lockout     = lockout;

endmodule
